// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - tiny16 sequencer opcodes, FSM states and ALU flag bit indices
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_BZ   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_ILL0 = 4'hD;
    localparam logic [3:0] OP_ILL1 = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam int FLAG_O = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        OPND   = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/fetch_port.sv
// rtl/fetch_port.sv - memory read handshake and program counter shared by instruction and operand fetch
module fetch_port #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              mem_ready,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              accept
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    // mem_rd is gated by rst so a reset mid-fetch drops the request without waiting for a clock
    always_comb begin
        mem_rd   = req && !rst;
        accept   = mem_rd && mem_ready;
        mem_addr = pc_q;
        pc_d     = pc_q;
        if (accept) begin
            pc_d = load_en ? load_pc : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - tiny16 fetch/decode/execute sequencer; CPU_CONTROL_ILLEGAL_TRAP_EN halts on 1101/1110
module cpu_control
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [15:0]       mem_data,
    output logic [3:0]        alu_opcode,
    output logic              alu_ar_flag,
    output logic              alu_out_en,
    input  logic [3:0]        alu_flags,
    output logic [2:0]        rs1_sel,
    output logic [2:0]        rs2_sel,
    output logic [2:0]        rd_sel,
    output logic              reg_we,
    output logic              wb_imm_sel,
    output logic [15:0]       imm_out,
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic              halted
);

    state_t      state_q, state_d;
    logic [15:2] ir_q, ir_d;
    logic [3:0]  alu_opcode_q, alu_opcode_d;
    logic        alu_ar_q, alu_ar_d;
    logic [2:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [15:0] imm_q, imm_d;
    logic [3:0]  op;
    logic        fetch_req, accept, pc_load;
    logic        unused_flags;

    assign op           = ir_q[15:12];
    assign fetch_req    = (state_q == FETCH) || (state_q == OPND);
    assign unused_flags = ^alu_flags[FLAG_O:FLAG_N];
    assign pc_load      = (state_q == OPND) &&
                          ((op == OP_JMP) || ((op == OP_BZ) && alu_flags[FLAG_Z]));

    fetch_port #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_fetch_port (
        .clk       (clk),
        .rst       (rst),
        .req       (fetch_req),
        .mem_ready (mem_ready),
        .load_en   (pc_load),
        .load_pc   (mem_data[ADDR_W-1:0]),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .accept    (accept)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (accept) state_d = DECODE;
            DECODE: begin
                if (is_alu_op(op)) begin
                    state_d = EXEC;
                end else if ((op == OP_LDI) || (op == OP_BZ) || (op == OP_JMP)) begin
                    state_d = OPND;
                end else if (op == OP_HLT) begin
                    state_d = HALT;
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
                end else if ((op == OP_ILL0) || (op == OP_ILL1)) begin
                    state_d = HALT;
`endif
                end else begin
                    state_d = FETCH;
                end
            end
            OPND:    if (accept) state_d = (op == OP_LDI) ? WB : FETCH;
            EXEC:    state_d = WB;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        reg_we     = (state_q == WB);
        alu_out_en = (state_q == WB) && (op != OP_LDI);
        wb_imm_sel = (state_q == WB) && (op == OP_LDI);
        halted     = (state_q == HALT);
    end

    // ALU controls load on the way into EXEC and then hold until the next ALU instruction
    always_comb begin
        ir_d         = ir_q;
        alu_opcode_d = alu_opcode_q;
        alu_ar_d     = alu_ar_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        imm_d        = imm_q;
        if ((state_q == FETCH) && accept) begin
            ir_d = mem_data[15:2];
        end
        if ((state_q == DECODE) && is_alu_op(op)) begin
            alu_opcode_d = op;
            alu_ar_d     = ir_q[11];
            rs1_d        = ir_q[7:5];
            rs2_d        = ir_q[4:2];
        end
        if ((state_d == WB) && (state_q != WB)) begin
            rd_d = ir_q[10:8];
        end
        if ((state_q == OPND) && accept && (op == OP_LDI)) begin
            imm_d = mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q         <= '0;
            alu_opcode_q <= '0;
            alu_ar_q     <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
        end else begin
            ir_q         <= ir_d;
            alu_opcode_q <= alu_opcode_d;
            alu_ar_q     <= alu_ar_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            imm_q        <= imm_d;
        end
    end

    assign alu_opcode  = alu_opcode_q;
    assign alu_ar_flag = alu_ar_q;
    assign rs1_sel     = rs1_q;
    assign rs2_sel     = rs2_q;
    assign rd_sel      = rd_q;
    assign imm_out     = imm_q;

`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if ((state_q == DECODE) && ((op == OP_ILL0) || (op == OP_ILL1))) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

endmodule
